// File: rtl/rom_layer_stream.sv
// Multi-layer weight ROM that streams one selected layer, one row per beat,
// over a valid/ready interface towards the neuron array's weight-load port.
module rom_layer_stream #(
    parameter int W_SIZE      = 8,
    parameter int NEURONS_IN  = 8,
    parameter int NEURONS_OUT = 2,
    parameter int N_LAYERS    = 2,
    parameter logic [N_LAYERS-1:0][NEURONS_IN-1:0][NEURONS_OUT*W_SIZE-1:0] ROM_MEM = '0,
    parameter int LSEL_W      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
    parameter int IDX_W       = (NEURONS_IN > 1) ? $clog2(NEURONS_IN) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LSEL_W-1:0]             layer_sel,
    output logic                          busy,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [NEURONS_OUT*W_SIZE-1:0] data,
    output logic [IDX_W-1:0]              row_idx,
    output logic                          last,
    output logic                          done,
    output logic                          err,
    output logic                          dbg_state
);

    // Handshake: a beat transfers on a rising edge where data_valid and
    // data_ready are both high; while data_valid is high and data_ready is low,
    // data, row_idx and last hold their values.

    localparam int ROW_W = NEURONS_OUT * W_SIZE;
    localparam logic [IDX_W-1:0]  FIRST_IDX  = '0;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NEURONS_IN - 1);
    localparam logic [LSEL_W:0]   N_LAYERS_C = (LSEL_W + 1)'(N_LAYERS);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t              r_state;
    logic [LSEL_W-1:0]   r_layer;
    logic [IDX_W-1:0]    r_row_idx;
    logic [ROW_W-1:0]    r_data;
    logic                r_valid;
    logic                r_busy;
    logic                r_last;
    logic                r_done;
    logic                r_err;

    logic                w_sel_ok;
    logic [IDX_W-1:0]    w_next_idx;

    // Zero-extend so out-of-range selects are detectable for non-power-of-two layer counts.
    assign w_sel_ok   = ({1'b0, layer_sel} < N_LAYERS_C);
    assign w_next_idx = r_row_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_layer   <= '0;
            r_row_idx <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_sel_ok) begin
                            r_state   <= S_STREAM;
                            r_layer   <= layer_sel;
                            r_row_idx <= FIRST_IDX;
                            r_data    <= ROM_MEM[layer_sel][FIRST_IDX];
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_last    <= (FIRST_IDX == LAST_IDX);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (data_ready) begin
                        if (r_row_idx == LAST_IDX) begin
                            r_state   <= S_IDLE;
                            r_row_idx <= '0;
                            r_data    <= '0;
                            r_valid   <= 1'b0;
                            r_busy    <= 1'b0;
                            r_last    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_row_idx <= w_next_idx;
                            r_data    <= ROM_MEM[r_layer][w_next_idx];
                            r_last    <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign data_valid = r_valid;
    assign data       = r_data;
    assign row_idx    = r_row_idx;
    assign last       = r_last;
    assign done       = r_done;
    assign err        = r_err;
    assign dbg_state  = r_state;

endmodule
